// File: rtl/data_mem_responder_if.sv
// Data-bus bundle between the core (master) and the data-memory responder (slave).
interface data_mem_responder_if;
    logic [31:0] address;
    logic [31:0] wdata;
    logic        wren;
    logic        rden;
    logic [2:0]  funct3;
    logic [31:0] rdata;
    logic        misaligned;
    logic        fault;

    modport master (
        output address, wdata, wren, rden, funct3,
        input  rdata, misaligned, fault
    );

    modport slave (
        input  address, wdata, wren, rden, funct3,
        output rdata, misaligned, fault
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-bus responder: byte-lane RAM stores, sign/zero-extended loads, misalignment and range flags.
// Define DMEM_MMIO_COUNTERS_EN to map a 64-bit cycle counter and a store counter into the MMIO window.
module data_mem_responder #(
    parameter int unsigned ADDR_W    = 10,
    parameter logic [31:0] RAM_BASE  = 32'h1001_0000,
    parameter logic [31:0] MMIO_BASE = 32'hFF20_0000
) (
    input  logic                clockMem,
    input  logic                reset,
    data_mem_responder_if.slave bus
);

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    localparam int unsigned WORDS = 1 << ADDR_W;

    logic [31:0]       mem [WORDS];

    logic [31:0]       offset;
    logic [ADDR_W-1:0] word_idx;
    logic              ram_hit;
    logic              mmio_hit;
    logic              legal;
    logic              align_err;
    logic              is_word;
    logic              access;
    logic              load_req;
    logic              acc_misaligned;
    logic              acc_fault;
    logic              acc_ok;
    logic              ram_we;
    logic [3:0]        lane_en;
    logic [31:0]       lane_data;
    logic [31:0]       mmio_word;
    logic [31:0]       src_word;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       load_val;

    logic [31:0]       rdata_q;
    logic              misaligned_q;
    logic              fault_q;

    // ---------------------------------------------------------------- decode
    assign offset   = bus.address - RAM_BASE;
    assign ram_hit  = (offset >> (ADDR_W + 2)) == 32'd0;
    assign word_idx = offset[ADDR_W+1:2];

`ifdef DMEM_MMIO_COUNTERS_EN
    assign mmio_hit = bus.address[31:4] == MMIO_BASE[31:4];
`else
    assign mmio_hit = 1'b0;
`endif

    always_comb begin
        // NOTE: every always_comb output is given a default first so no path can infer a latch.
        legal     = 1'b1;
        align_err = 1'b0;
        is_word   = 1'b0;
        lane_en   = 4'b0000;
        lane_data = bus.wdata;
        case (bus.funct3)
            F3_B, F3_BU: begin
                lane_en   = 4'b0001 << bus.address[1:0];
                lane_data = {4{bus.wdata[7:0]}};
            end
            F3_H, F3_HU: begin
                align_err = bus.address[0];
                lane_en   = bus.address[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{bus.wdata[15:0]}};
            end
            F3_W: begin
                align_err = |bus.address[1:0];
                is_word   = 1'b1;
                lane_en   = 4'b1111;
            end
            default: legal = 1'b0;
        endcase
    end

    // The counter window only answers aligned word accesses; anything narrower is a fault.
    assign access         = bus.wren | bus.rden;
    assign load_req       = bus.rden & ~bus.wren;
    assign acc_misaligned = legal & align_err;
    assign acc_fault      = ~legal | ~(ram_hit | mmio_hit) | (mmio_hit & ~is_word);
    assign acc_ok         = ~acc_misaligned & ~acc_fault;
    assign ram_we         = bus.wren & acc_ok & ram_hit;

    // ---------------------------------------------------------------- RAM
    // NOTE: the RAM array has no reset branch; contents survive reset and map onto plain RAM cells.
    always_ff @(posedge clockMem) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem[word_idx][8*i +: 8] <= lane_data[8*i +: 8];
                end
            end
        end
    end

    // ---------------------------------------------------------------- counters
`ifdef DMEM_MMIO_COUNTERS_EN
    typedef enum logic [1:0] {
        MMIO_CYC_LO = 2'd0,
        MMIO_CYC_HI = 2'd1,
        MMIO_STORES = 2'd2,
        MMIO_RSVD   = 2'd3
    } mmio_reg_e;

    logic [63:0] cycle_cnt;
    logic [63:0] next_cycle;
    logic [31:0] shadow_hi;
    logic [31:0] store_cnt;
    logic        mmio_we;
    logic        mmio_rd;
    mmio_reg_e   mmio_sel;

    // A cycle read returns the count including the edge that samples it.
    assign next_cycle = cycle_cnt + 64'd1;
    assign mmio_sel   = mmio_reg_e'(bus.address[3:2]);
    assign mmio_we    = bus.wren & acc_ok & mmio_hit;
    assign mmio_rd    = load_req & acc_ok & mmio_hit;

    always_comb begin
        mmio_word = 32'd0;
        case (mmio_sel)
            MMIO_CYC_LO: mmio_word = next_cycle[31:0];
            MMIO_CYC_HI: mmio_word = shadow_hi;
            MMIO_STORES: mmio_word = store_cnt;
            MMIO_RSVD:   mmio_word = 32'd0;
            default:     mmio_word = 32'd0;
        endcase
    end

    always_ff @(posedge clockMem or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= 64'd0;
            shadow_hi <= 32'd0;
            store_cnt <= 32'd0;
        end else begin
            if (mmio_we && mmio_sel == MMIO_CYC_LO) begin
                cycle_cnt <= 64'd0;
                shadow_hi <= 32'd0;
            end else begin
                cycle_cnt <= next_cycle;
                if (mmio_rd && mmio_sel == MMIO_CYC_LO) begin
                    shadow_hi <= next_cycle[63:32];
                end
            end

            if (mmio_we && mmio_sel == MMIO_STORES) begin
                store_cnt <= 32'd0;
            end else if (ram_we) begin
                store_cnt <= store_cnt + 32'd1;
            end
        end
    end
`else
    assign mmio_word = 32'd0;
`endif

    // ---------------------------------------------------------------- load path
    assign src_word = ram_hit ? mem[word_idx] : mmio_word;

    always_comb begin
        ld_byte = src_word[7:0];
        case (bus.address[1:0])
            2'd1:    ld_byte = src_word[15:8];
            2'd2:    ld_byte = src_word[23:16];
            2'd3:    ld_byte = src_word[31:24];
            default: ld_byte = src_word[7:0];
        endcase
        ld_half = bus.address[1] ? src_word[31:16] : src_word[15:0];

        load_val = 32'd0;
        case (bus.funct3)
            F3_B:    load_val = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   load_val = {24'd0, ld_byte};
            F3_H:    load_val = {{16{ld_half[15]}}, ld_half};
            F3_HU:   load_val = {16'd0, ld_half};
            F3_W:    load_val = src_word;
            default: load_val = 32'd0;
        endcase
    end

    // ---------------------------------------------------------------- response registers
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clockMem or negedge reset) begin
        if (!reset) begin
            rdata_q      <= 32'd0;
            misaligned_q <= 1'b0;
            fault_q      <= 1'b0;
        end else if (access) begin
            misaligned_q <= acc_misaligned;
            fault_q      <= acc_fault;
            if (!acc_ok) begin
                rdata_q <= 32'd0;
            end else if (load_req) begin
                rdata_q <= load_val;
            end
        end
    end

    assign bus.rdata      = rdata_q;
    assign bus.misaligned = misaligned_q;
    assign bus.fault      = fault_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus random traffic against a byte-array model.
module tb_data_mem_responder;

    localparam int unsigned ADDR_W    = 10;
    localparam logic [31:0] RAM_BASE  = 32'h1001_0000;
    localparam logic [31:0] MMIO_BASE = 32'hFF20_0000;
    localparam int unsigned RAM_BYTES = 4 << ADDR_W;

    localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

    logic clockMem = 1'b0;
    logic reset;

    data_mem_responder_if bus ();

    data_mem_responder #(
        .ADDR_W   (ADDR_W),
        .RAM_BASE (RAM_BASE),
        .MMIO_BASE(MMIO_BASE)
    ) dut (
        .clockMem(clockMem),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clockMem = ~clockMem;

    int tests_run    = 0;
    int tests_failed = 0;

    // Byte-addressed image of the RAM plus the expected response registers.
    logic [7:0]  ref_mem [RAM_BYTES];
    logic [31:0] exp_rdata;
    logic        exp_mis;
    logic        exp_fault;

    logic [31:0] obs_rdata;
    logic        obs_mis;
    logic        obs_fault;

    task automatic model_access(input logic wr, input logic rd, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wd);
        int          size;
        bit          legal;
        bit          sgn;
        logic [31:0] off;
        logic [31:0] val;
        if (!wr && !rd) return;
        legal = 1'b1;
        sgn   = 1'b0;
        size  = 1;
        case (f3)
            F_B:     begin size = 1; sgn = 1'b1; end
            F_H:     begin size = 2; sgn = 1'b1; end
            F_W:     size = 4;
            F_BU:    size = 1;
            F_HU:    size = 2;
            default: legal = 1'b0;
        endcase
        off       = addr - RAM_BASE;
        exp_mis   = legal && (addr % size != 0);
        exp_fault = !legal || !(off < RAM_BYTES);
        if (exp_mis || exp_fault) begin
            exp_rdata = 32'd0;
            return;
        end
        if (wr) begin
            for (int k = 0; k < size; k++) ref_mem[off + k] = wd[8*k +: 8];
            return;
        end
        val = 32'd0;
        for (int k = 0; k < size; k++) val = val | (32'(ref_mem[off + k]) << (8 * k));
        if (sgn && val[8*size-1]) val = val | (32'hFFFF_FFFF << (8 * size));
        exp_rdata = val;
    endtask

    // Drive one request for one edge, sample just after it, then update the model.
    task automatic access(input logic wr, input logic rd, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd);
        bus.wren    = wr;
        bus.rden    = rd;
        bus.funct3  = f3;
        bus.address = addr;
        bus.wdata   = wd;
        @(posedge clockMem);
        #1;
        bus.wren  = 1'b0;
        bus.rden  = 1'b0;
        obs_rdata = bus.rdata;
        obs_mis   = bus.misaligned;
        obs_fault = bus.fault;
        model_access(wr, rd, f3, addr, wd);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        @(negedge clockMem);
        @(negedge clockMem);
        reset = 1'b1;
        @(posedge clockMem);
        #1;
        exp_rdata = 32'd0;
        exp_mis   = 1'b0;
        exp_fault = 1'b0;
    endtask

    task automatic test_reset();
        reset       = 1'b0;
        bus.wren    = 1'b0;
        bus.rden    = 1'b1;
        bus.funct3  = F_W;
        bus.address = RAM_BASE;
        bus.wdata   = 32'd0;
        repeat (3) @(posedge clockMem);
        #1;
        tests_run++;
        if ({bus.rdata, bus.misaligned, bus.fault} !== 34'd0) begin
            tests_failed++;
            $display("FAIL reset_hold: rdata=%h mis=%b fault=%b, expected 0/0/0",
                     bus.rdata, bus.misaligned, bus.fault);
        end
        bus.rden = 1'b0;
        @(negedge clockMem);
        reset = 1'b1;
        @(posedge clockMem);
        #1;
        exp_rdata = 32'd0;
        exp_mis   = 1'b0;
        exp_fault = 1'b0;
        // Give the first 16 words known contents so every later load has a defined answer.
        for (int w = 0; w < 16; w++) access(1'b1, 1'b0, F_W, RAM_BASE + 32'(4 * w), $urandom);
    endtask

    task automatic test_byte_lanes();
        access(1'b1, 1'b0, F_W, 32'h1001_0000, 32'hAABB_CCDD);
        access(1'b1, 1'b0, F_B, 32'h1001_0001, 32'h0000_0011);
        access(1'b0, 1'b1, F_W, 32'h1001_0000, 32'd0);
        tests_run++;
        if ({obs_rdata, obs_mis, obs_fault} !== {32'hAABB_11DD, 2'b00}) begin
            tests_failed++;
            $display("FAIL lane_merge: rdata=%h mis=%b fault=%b, expected aabb11dd/0/0",
                     obs_rdata, obs_mis, obs_fault);
        end
    endtask

    task automatic test_extension();
        logic [2:0]  f3s  [4] = '{F_B, F_BU, F_H, F_HU};
        logic [31:0] adrs [4] = '{32'h1001_0003, 32'h1001_0003, 32'h1001_0002, 32'h1001_0002};
        logic [31:0] exps [4] = '{32'hFFFF_FFAA, 32'h0000_00AA, 32'hFFFF_AABB, 32'h0000_AABB};
        for (int i = 0; i < 4; i++) begin
            access(1'b0, 1'b1, f3s[i], adrs[i], 32'd0);
            tests_run++;
            if ({obs_rdata, obs_mis, obs_fault} !== {exps[i], 2'b00}) begin
                tests_failed++;
                $display("FAIL extend_f3_%b: rdata=%h mis=%b fault=%b, expected %h/0/0",
                         f3s[i], obs_rdata, obs_mis, obs_fault, exps[i]);
            end
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] prior;
        access(1'b0, 1'b1, F_W, 32'h1001_0002, 32'd0);
        tests_run++;
        if ({obs_rdata, obs_mis, obs_fault} !== {32'd0, 2'b10}) begin
            tests_failed++;
            $display("FAIL misaligned_lw: rdata=%h mis=%b fault=%b, expected 0/1/0",
                     obs_rdata, obs_mis, obs_fault);
        end
        prior = {ref_mem[7], ref_mem[6], ref_mem[5], ref_mem[4]};
        access(1'b1, 1'b0, F_H, 32'h1001_0005, 32'h0000_1234);
        tests_run++;
        if ({obs_mis, obs_fault} !== 2'b10) begin
            tests_failed++;
            $display("FAIL misaligned_sh: mis=%b fault=%b, expected 1/0", obs_mis, obs_fault);
        end
        access(1'b0, 1'b1, F_W, 32'h1001_0004, 32'd0);
        tests_run++;
        if ({obs_rdata, obs_mis, obs_fault} !== {prior, 2'b00}) begin
            tests_failed++;
            $display("FAIL misaligned_sh_kept: rdata=%h mis=%b fault=%b, expected %h/0/0",
                     obs_rdata, obs_mis, obs_fault, prior);
        end
    endtask

    task automatic test_range_funct3();
        logic [31:0] prior;
        logic [31:0] top_val;
        access(1'b0, 1'b1, F_W, 32'h1001_1000, 32'd0);
        tests_run++;
        if ({obs_rdata, obs_mis, obs_fault} !== {32'd0, 2'b01}) begin
            tests_failed++;
            $display("FAIL range_above: rdata=%h mis=%b fault=%b, expected 0/0/1",
                     obs_rdata, obs_mis, obs_fault);
        end
        access(1'b0, 1'b1, F_W, RAM_BASE - 32'd4, 32'd0);
        tests_run++;
        if ({obs_rdata, obs_mis, obs_fault} !== {32'd0, 2'b01}) begin
            tests_failed++;
            $display("FAIL range_below: rdata=%h mis=%b fault=%b, expected 0/0/1",
                     obs_rdata, obs_mis, obs_fault);
        end
        prior = {ref_mem[11], ref_mem[10], ref_mem[9], ref_mem[8]};
        access(1'b1, 1'b0, 3'b011, 32'h1001_0008, ~prior);
        tests_run++;
        if ({obs_rdata, obs_fault} !== {32'd0, 1'b1}) begin
            tests_failed++;
            $display("FAIL illegal_f3_store: rdata=%h fault=%b, expected 0/1", obs_rdata, obs_fault);
        end
        access(1'b0, 1'b1, F_W, 32'h1001_0008, 32'd0);
        tests_run++;
        if ({obs_rdata, obs_mis, obs_fault} !== {prior, 2'b00}) begin
            tests_failed++;
            $display("FAIL illegal_f3_kept: rdata=%h mis=%b fault=%b, expected %h/0/0",
                     obs_rdata, obs_mis, obs_fault, prior);
        end
        top_val = $urandom;
        access(1'b1, 1'b0, F_W, 32'h1001_0FFC, top_val);
        access(1'b0, 1'b1, F_W, 32'h1001_0FFC, 32'd0);
        tests_run++;
        if ({obs_rdata, obs_mis, obs_fault} !== {top_val, 2'b00}) begin
            tests_failed++;
            $display("FAIL last_word: rdata=%h mis=%b fault=%b, expected %h/0/0",
                     obs_rdata, obs_mis, obs_fault, top_val);
        end
    endtask

    task automatic test_simultaneous();
        access(1'b1, 1'b0, F_W, 32'h1001_0000, 32'hAABB_11DD);
        access(1'b0, 1'b1, F_W, 32'h1001_0000, 32'd0);
        access(1'b1, 1'b1, F_W, 32'h1001_000C, 32'h5566_7788);
        tests_run++;
        if ({obs_rdata, obs_mis, obs_fault} !== {32'hAABB_11DD, 2'b00}) begin
            tests_failed++;
            $display("FAIL simul_hold: rdata=%h mis=%b fault=%b, expected aabb11dd/0/0",
                     obs_rdata, obs_mis, obs_fault);
        end
        access(1'b0, 1'b1, F_W, 32'h1001_000C, 32'd0);
        tests_run++;
        if (obs_rdata !== 32'h5566_7788) begin
            tests_failed++;
            $display("FAIL simul_stored: rdata=%h, expected 55667788", obs_rdata);
        end
    endtask

    task automatic test_random();
        logic        wr;
        logic        rd;
        logic [2:0]  f3;
        logic [31:0] addr;
        access(1'b0, 1'b1, F_W, RAM_BASE, 32'd0);
        for (int n = 0; n < 300; n++) begin
            wr = 1'($urandom);
            rd = 1'($urandom);
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0:       addr = RAM_BASE + RAM_BYTES + 32'($urandom_range(0, 15));
                1:       addr = RAM_BASE - 32'd1 - 32'($urandom_range(0, 15));
                default: addr = RAM_BASE + 32'($urandom_range(0, 63));
            endcase
            access(wr, rd, f3, addr, $urandom);
            tests_run++;
            if ({obs_rdata, obs_mis, obs_fault} !== {exp_rdata, exp_mis, exp_fault}) begin
                tests_failed++;
                $display("FAIL random_%0d wr=%b rd=%b f3=%b addr=%h: rdata=%h mis=%b fault=%b, expected %h/%b/%b",
                         n, wr, rd, f3, addr, obs_rdata, obs_mis, obs_fault, exp_rdata, exp_mis, exp_fault);
            end
        end
    endtask

`ifdef DMEM_MMIO_COUNTERS_EN
    task automatic test_counters();
        apply_reset();
        repeat (98) @(posedge clockMem);
        #1;
        // Edge 100 after release samples this read.
        access(1'b0, 1'b1, F_W, MMIO_BASE, 32'd0);
        tests_run++;
        if ({obs_rdata, obs_mis, obs_fault} !== {32'd100, 2'b00}) begin
            tests_failed++;
            $display("FAIL cycle_low: rdata=%0d mis=%b fault=%b, expected 100/0/0",
                     obs_rdata, obs_mis, obs_fault);
        end
        access(1'b0, 1'b1, F_W, MMIO_BASE + 32'h4, 32'd0);
        tests_run++;
        if (obs_rdata !== 32'd0) begin
            tests_failed++;
            $display("FAIL cycle_high: rdata=%h, expected 0", obs_rdata);
        end
        for (int i = 0; i < 3; i++) access(1'b1, 1'b0, F_W, RAM_BASE + 32'(80 + 4 * i), $urandom);
        access(1'b1, 1'b0, F_W, RAM_BASE + 32'd90, $urandom);
        access(1'b0, 1'b1, F_W, MMIO_BASE + 32'h8, 32'd0);
        tests_run++;
        if (obs_rdata !== 32'd3) begin
            tests_failed++;
            $display("FAIL store_count: rdata=%0d, expected 3", obs_rdata);
        end
        access(1'b0, 1'b1, F_B, MMIO_BASE, 32'd0);
        tests_run++;
        if ({obs_rdata, obs_mis, obs_fault} !== {32'd0, 2'b01}) begin
            tests_failed++;
            $display("FAIL mmio_byte: rdata=%h mis=%b fault=%b, expected 0/0/1",
                     obs_rdata, obs_mis, obs_fault);
        end
        access(1'b1, 1'b0, F_W, MMIO_BASE + 32'h8, 32'd0);
        access(1'b0, 1'b1, F_W, MMIO_BASE + 32'h8, 32'd0);
        tests_run++;
        if (obs_rdata !== 32'd0) begin
            tests_failed++;
            $display("FAIL store_count_clear: rdata=%0d, expected 0", obs_rdata);
        end
        access(1'b1, 1'b0, F_W, MMIO_BASE, 32'd0);
        access(1'b0, 1'b1, F_W, MMIO_BASE, 32'd0);
        tests_run++;
        if (obs_rdata < 32'd1 || obs_rdata > 32'd2 || obs_fault !== 1'b0) begin
            tests_failed++;
            $display("FAIL cycle_clear: rdata=%0d fault=%b, expected 1..2/0", obs_rdata, obs_fault);
        end
    endtask
`else
    task automatic test_counters();
        access(1'b0, 1'b1, F_W, MMIO_BASE, 32'd0);
        tests_run++;
        if ({obs_rdata, obs_mis, obs_fault} !== {32'd0, 2'b01}) begin
            tests_failed++;
            $display("FAIL mmio_absent_rd: rdata=%h mis=%b fault=%b, expected 0/0/1",
                     obs_rdata, obs_mis, obs_fault);
        end
        access(1'b1, 1'b0, F_W, MMIO_BASE + 32'h8, 32'd0);
        tests_run++;
        if ({obs_mis, obs_fault} !== 2'b01) begin
            tests_failed++;
            $display("FAIL mmio_absent_wr: mis=%b fault=%b, expected 0/1", obs_mis, obs_fault);
        end
    endtask
`endif

    task automatic test_reset_mid_op();
        access(1'b1, 1'b0, F_W, RAM_BASE, 32'hCAFE_F00D);
        access(1'b0, 1'b1, F_W, RAM_BASE, 32'd0);
        tests_run++;
        if (obs_rdata !== 32'hCAFE_F00D) begin
            tests_failed++;
            $display("FAIL pre_reset_load: rdata=%h, expected cafef00d", obs_rdata);
        end
        #2;
        reset = 1'b0;
        #1;
        tests_run++;
        if ({bus.rdata, bus.misaligned, bus.fault} !== 34'd0) begin
            tests_failed++;
            $display("FAIL async_reset: rdata=%h mis=%b fault=%b, expected 0/0/0",
                     bus.rdata, bus.misaligned, bus.fault);
        end
        @(negedge clockMem);
        reset = 1'b1;
        @(posedge clockMem);
        #1;
        access(1'b0, 1'b1, F_W, RAM_BASE, 32'd0);
        tests_run++;
        if (obs_rdata !== 32'hCAFE_F00D) begin
            tests_failed++;
            $display("FAIL ram_survives_reset: rdata=%h, expected cafef00d", obs_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_byte_lanes();
        test_extension();
        test_misaligned();
        test_range_funct3();
        test_simultaneous();
        test_random();
        test_counters();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
